// File: rtl/fabric_prog_pkg.sv
`default_nettype none
// =============================================================================
//  Module      : fabric_prog_pkg
//  Description : Shared states, byte width and counter sizing helpers.
//  Revision    : 1.0
// =============================================================================
package fabric_prog_pkg;

    localparam int c_BYTE_W = 8;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LOAD  = 3'd1,
        ST_SETUP = 3'd2,
        ST_HIGH  = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

    // Width of a down-counter holding 0 .. n-1.
    function automatic int cnt_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Bit counter holds 0 .. n; low three bits double as the in-byte index.
    function automatic int bit_cnt_w(input int n);
        int w;
        w = $clog2(n + 1);
        return (w < 3) ? 3 : w;
    endfunction

endpackage
`default_nettype wire

// File: rtl/prog_phase_timer.sv
`default_nettype none
// =============================================================================
//  Module      : prog_phase_timer
//  Description : CLK_DIV-cycle phase down-counter with last-cycle strobe.
//  Revision    : 1.0
// =============================================================================
module prog_phase_timer
    import fabric_prog_pkg::*;
#(
    parameter int CLK_DIV = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic i_restart,
    output logic o_phase_last
);

    localparam int              c_CW     = cnt_w(CLK_DIV);
    localparam logic [c_CW-1:0] c_RELOAD = c_CW'(CLK_DIV - 1);

    logic [c_CW-1:0] r_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (i_restart) begin
            r_cnt <= c_RELOAD;
        end else if (r_cnt != '0) begin
            r_cnt <= r_cnt - 1'b1;
        end
    end

    assign o_phase_last = (r_cnt == '0);

endmodule
`default_nettype wire

// File: rtl/fabric_programmer.sv
`default_nettype none
// =============================================================================
//  Module      : fabric_programmer
//  Description : Serializes config bytes onto the fabric chain, returns readback.
//  Revision    : 1.0
// =============================================================================
module fabric_programmer
    import fabric_prog_pkg::*;
#(
    parameter int CHAIN_LEN = 240,
    parameter int CLK_DIV   = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       i_start,
    input  logic [7:0] i_cfg_data,
    input  logic       i_cfg_valid,
    output logic       o_cfg_ready,
    output logic [7:0] o_rd_data,
    output logic       o_rd_valid,
    output logic       o_busy,
    output logic       o_done,
    output logic       o_prog_clk,
    output logic       o_prog_en,
    output logic       o_prog_in,
    input  logic       i_prog_out
);

    localparam int             c_BW      = bit_cnt_w(CHAIN_LEN);
    localparam logic [c_BW-1:0] c_LAST   = c_BW'(CHAIN_LEN);
    localparam bit             c_PARTIAL = (CHAIN_LEN % c_BYTE_W) != 0;
    localparam int             c_PAD     = (c_BYTE_W - (CHAIN_LEN % c_BYTE_W)) % c_BYTE_W;

    state_t            r_state;
    state_t            w_next;
    logic [6:0]        r_shreg;
    logic [7:0]        r_rd_sh;
    logic [c_BW-1:0]   r_bit_cnt;
    logic [c_BW-1:0]   w_bit_inc;
    logic              w_phase_last;
    logic              w_restart;
    logic              w_hs;

    logic       r_cfg_ready, r_rd_valid, r_busy, r_done;
    logic       r_prog_clk, r_prog_en, r_prog_in;
    logic [7:0] r_rd_data;

    assign w_bit_inc = r_bit_cnt + 1'b1;
    assign w_hs      = r_cfg_ready && i_cfg_valid;
    assign w_restart = (w_next != r_state);

    prog_phase_timer #(
        .CLK_DIV (CLK_DIV)
    ) u_timer (
        .clk          (clk),
        .rst          (rst),
        .i_restart    (w_restart),
        .o_phase_last (w_phase_last)
    );

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            ST_IDLE:  if (i_start) w_next = ST_LOAD;
            ST_LOAD:  if (i_cfg_valid) w_next = ST_SETUP;
            ST_SETUP: if (w_phase_last) w_next = ST_HIGH;
            ST_HIGH: begin
                if (w_phase_last) begin
                    if (w_bit_inc == c_LAST)        w_next = ST_DONE;
                    else if (w_bit_inc[2:0] == 3'd0) w_next = ST_LOAD;
                    else                             w_next = ST_SETUP;
                end
            end
            ST_DONE:  w_next = ST_IDLE;
            default:  w_next = ST_IDLE;
        endcase
    end

    // Outputs are registered from the next state so they line up with r_state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_shreg     <= '0;
            r_rd_sh     <= '0;
            r_bit_cnt   <= '0;
            r_cfg_ready <= 1'b0;
            r_rd_valid  <= 1'b0;
            r_rd_data   <= '0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_prog_clk  <= 1'b0;
            r_prog_en   <= 1'b0;
            r_prog_in   <= 1'b0;
        end else begin
            r_state     <= w_next;
            r_cfg_ready <= (w_next == ST_LOAD);
            r_prog_en   <= (w_next inside {ST_LOAD, ST_SETUP, ST_HIGH});
            r_prog_clk  <= (w_next == ST_HIGH);
            r_done      <= (w_next == ST_DONE);
            r_busy      <= (w_next != ST_IDLE);
            r_rd_valid  <= 1'b0;

            if (r_state == ST_IDLE && i_start) begin
                r_bit_cnt <= '0;
            end
            if (w_hs) begin
                r_shreg   <= i_cfg_data[6:0];
                r_prog_in <= i_cfg_data[7];
            end
            // Chain tail is sampled just before the rising prog_clk shifts it.
            if (r_state == ST_SETUP && w_phase_last) begin
                r_rd_sh <= {r_rd_sh[6:0], i_prog_out};
                if (r_bit_cnt[2:0] == 3'd7) begin
                    r_rd_data  <= {r_rd_sh[6:0], i_prog_out};
                    r_rd_valid <= 1'b1;
                end
            end
            if (r_state == ST_HIGH && w_phase_last) begin
                r_bit_cnt <= w_bit_inc;
                r_shreg   <= {r_shreg[5:0], 1'b0};
                if (w_next == ST_SETUP) begin
                    r_prog_in <= r_shreg[6];
                end
                if (w_next == ST_DONE) begin
                    r_prog_in <= 1'b0;
                    if (c_PARTIAL) begin
                        r_rd_data  <= r_rd_sh << c_PAD;
                        r_rd_valid <= 1'b1;
                    end
                end
            end
        end
    end

    assign o_cfg_ready = r_cfg_ready;
    assign o_rd_data   = r_rd_data;
    assign o_rd_valid  = r_rd_valid;
    assign o_busy      = r_busy;
    assign o_done      = r_done;
    assign o_prog_clk  = r_prog_clk;
    assign o_prog_en   = r_prog_en;
    assign o_prog_in   = r_prog_in;

endmodule
`default_nettype wire

// File: tb/tb_fabric_programmer.sv
`default_nettype none
// =============================================================================
//  Module      : tb_fabric_programmer
//  Description : Scoreboard bench: chain models on a 16-bit/div-1 and a 12-bit/div-3 DUT.
//  Revision    : 1.0
// =============================================================================
module tb_fabric_programmer;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic [1:0]       s_start, s_vld;
    logic [7:0]       s_dat [2];
    logic [1:0]       w_rdy, w_rdv, w_busy, w_done, w_pclk, w_pen, w_pin, w_pout;
    logic [1:0][7:0]  w_rdd;

    int               n_chk, n_fail;
    int               pulses [2];
    int               dones  [2];
    int               remain [2];
    logic [15:0]      r_chain [2];
    logic             q_bits [2][$];
    logic [7:0]       q_rd   [2][$];
    logic [1:0]       r_pclk_d;
    int               hi_cnt, lo_cnt;
    bit               lo_clean;

    assign w_pout[0] = r_chain[0][15];
    assign w_pout[1] = r_chain[1][11];

    fabric_programmer #(.CHAIN_LEN(16), .CLK_DIV(1)) u_a (
        .clk(clk), .rst(rst), .i_start(s_start[0]), .i_cfg_data(s_dat[0]),
        .i_cfg_valid(s_vld[0]), .o_cfg_ready(w_rdy[0]), .o_rd_data(w_rdd[0]),
        .o_rd_valid(w_rdv[0]), .o_busy(w_busy[0]), .o_done(w_done[0]),
        .o_prog_clk(w_pclk[0]), .o_prog_en(w_pen[0]), .o_prog_in(w_pin[0]),
        .i_prog_out(w_pout[0])
    );

    fabric_programmer #(.CHAIN_LEN(12), .CLK_DIV(3)) u_b (
        .clk(clk), .rst(rst), .i_start(s_start[1]), .i_cfg_data(s_dat[1]),
        .i_cfg_valid(s_vld[1]), .o_cfg_ready(w_rdy[1]), .o_rd_data(w_rdd[1]),
        .o_rd_valid(w_rdv[1]), .o_busy(w_busy[1]), .o_done(w_done[1]),
        .o_prog_clk(w_pclk[1]), .o_prog_en(w_pen[1]), .o_prog_in(w_pin[1]),
        .i_prog_out(w_pout[1])
    );

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
        end
    endtask

    function automatic logic [14:0] outs(input int i);
        return {w_rdd[i], w_rdv[i], w_busy[i], w_done[i], w_rdy[i], w_pclk[i], w_pen[i], w_pin[i]};
    endfunction

    function automatic int len_of(input int i);
        return (i == 0) ? 16 : 12;
    endfunction

    // Fabric chain model, bit scoreboard, readback scoreboard and phase timing.
    initial begin
        r_pclk_d = '0;
        hi_cnt   = 0;
        lo_cnt   = 0;
        lo_clean = 1'b0;
        forever begin
            @(negedge clk);
            for (int i = 0; i < 2; i++) begin
                if (w_pclk[i] && !r_pclk_d[i]) begin
                    pulses[i]++;
                    check_eq("bit_expected", q_bits[i].size() > 0, 1);
                    if (q_bits[i].size() > 0) check_eq("prog_in", w_pin[i], q_bits[i].pop_front());
                    r_chain[i] = {r_chain[i][14:0], w_pin[i]};
                end
                if (w_rdv[i]) begin
                    check_eq("rd_expected", q_rd[i].size() > 0, 1);
                    if (q_rd[i].size() > 0) check_eq("rd_data", w_rdd[i], q_rd[i].pop_front());
                end
                if (w_done[i]) dones[i]++;
            end
            if (w_pclk[1]) begin
                if (!r_pclk_d[1]) begin
                    if (lo_clean) check_eq("lo_len", lo_cnt, 3);
                    hi_cnt = 1;
                end else begin
                    hi_cnt++;
                end
            end else begin
                if (r_pclk_d[1]) begin
                    if (w_pen[1]) check_eq("hi_len", hi_cnt, 3);
                    lo_cnt   = 1;
                    lo_clean = 1'b1;
                end else begin
                    lo_cnt++;
                end
                if (w_rdy[1] || !w_pen[1]) lo_clean = 1'b0;
            end
            r_pclk_d = w_pclk;
        end
    end

    task automatic begin_pass(input int i, input logic [15:0] preload);
        int len;
        logic [7:0] e;
        len        = len_of(i);
        r_chain[i] = preload;
        for (int b = 0; b < len; b += 8) begin
            e = '0;
            for (int k = 0; k < 8; k++) if (b + k < len) e[7-k] = preload[len-1-b-k];
            q_rd[i].push_back(e);
        end
        pulses[i] = 0;
        dones[i]  = 0;
        remain[i] = len;
        @(negedge clk) s_start[i] = 1'b1;
        @(negedge clk) s_start[i] = 1'b0;
        check_eq("start_resp", {w_rdy[i], w_pen[i], w_busy[i]}, 3'b111);
    endtask

    task automatic send_byte(input int i, input logic [7:0] b);
        int n;
        n = 0;
        for (int k = 0; k < 8; k++) begin
            if (remain[i] > 0) begin
                q_bits[i].push_back(b[7-k]);
                remain[i]--;
            end
        end
        s_dat[i] = b;
        s_vld[i] = 1'b1;
        while (!w_rdy[i] && n < 200) begin
            @(negedge clk);
            n++;
        end
        check_eq("hs_wait", n < 200, 1);
        @(posedge clk);
        #1 s_vld[i] = 1'b0;
    endtask

    task automatic finish_pass(input int i, input logic [15:0] exp_chain);
        int n;
        logic [15:0] mask;
        n    = 0;
        mask = 16'hFFFF >> (16 - len_of(i));
        while (dones[i] == 0 && n < 500) begin
            @(negedge clk);
            n++;
        end
        check_eq("done_wait", n < 500, 1);
        repeat (3) @(negedge clk);
        check_eq("pulse_cnt", pulses[i], len_of(i));
        check_eq("done_cnt", dones[i], 1);
        check_eq("idle_after", {w_pen[i], w_busy[i], w_pclk[i], w_rdy[i]}, 4'b0000);
        check_eq("bits_left", q_bits[i].size(), 0);
        check_eq("rd_left", q_rd[i].size(), 0);
        check_eq("chain", r_chain[i] & mask, exp_chain);
    endtask

    initial begin
        int bad;
        int n;
        n_chk = 0;
        n_fail = 0;
        s_start = '0;
        s_vld = '0;
        s_dat[0] = '0;
        s_dat[1] = '0;
        r_chain[0] = '0;
        r_chain[1] = '0;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        check_eq("rst_a", outs(0), 0);
        check_eq("rst_b", outs(1), 0);
        rst = 1'b0;
        @(negedge clk);

        // Loopback readback of the old chain contents.
        begin_pass(0, 16'hBEEF);
        send_byte(0, 8'h12);
        send_byte(0, 8'h34);
        finish_pass(0, 16'h1234);

        // Stall between bytes, with a start pulse while busy.
        begin_pass(0, r_chain[0]);
        send_byte(0, 8'hA5);
        @(negedge clk) s_start[0] = 1'b1;
        @(negedge clk) s_start[0] = 1'b0;
        n = 0;
        while (!w_rdy[0] && n < 200) begin
            @(negedge clk);
            n++;
        end
        check_eq("stall_load_wait", n < 200, 1);
        bad = 0;
        repeat (20) begin
            @(negedge clk);
            if (w_pclk[0] || !w_pen[0]) bad++;
        end
        check_eq("stall_hold", bad, 0);
        send_byte(0, 8'h3C);
        finish_pass(0, 16'hA53C);

        // Chain length not a multiple of eight, slow prog_clk.
        begin_pass(1, 16'h0ABC);
        send_byte(1, 8'hFF);
        send_byte(1, 8'hF0);
        finish_pass(1, 16'h0FFF);

        // Asynchronous reset after the fifth rising prog_clk edge.
        begin_pass(1, r_chain[1]);
        send_byte(1, 8'h00);
        n = 0;
        while (pulses[1] < 5 && n < 200) begin
            @(negedge clk);
            n++;
        end
        check_eq("abort_wait", n < 200, 1);
        @(posedge clk);
        #2 rst = 1'b1;
        #1 check_eq("rst_async_b", outs(1), 0);
        @(negedge clk);
        check_eq("rdy_in_rst", w_rdy[1], 1'b0);
        check_eq("rst_held_b", outs(1), 0);
        rst = 1'b0;
        q_bits[1].delete();
        q_rd[1].delete();
        check_eq("abort_pulses", pulses[1], 5);
        check_eq("chain_abort", r_chain[1] & 16'h0FFF, 16'h0FE0);
        @(negedge clk);

        begin_pass(1, r_chain[1]);
        send_byte(1, 8'h5A);
        send_byte(1, 8'h30);
        finish_pass(1, 16'h05A3);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire

// File: doc/fabric_programmer.md
# fabric_programmer

Host-side driver for the fabric's serial configuration chain. It takes configuration bytes over a valid/ready stream and serializes them MSB-first onto `prog_in`, generating `prog_clk` and `prog_en`. It captures the old chain contents arriving on `prog_out` and returns them as readback bytes. It sits between an on-board controller (UART/SPI bridge) and the `prog_*` pins of the FPGA core.

## Interface
- `CHAIN_LEN`, 240: total configuration bits in the chain, ≥1; need not be a multiple of 8.
- `CLK_DIV`, 2: `clk` cycles per `prog_clk` half-period, ≥1.
- `clk`  in  1  system clock.
- `rst`  in  1  reset, asynchronous, active-high.
- `start`  in  1  begin a programming pass; honored only in IDLE.
- `cfg_data`  in  8  configuration byte, bit 7 shifted first.
- `cfg_valid`  in  1  `cfg_data` valid.
- `cfg_ready`  out  1  byte accepted when `cfg_valid && cfg_ready`.
- `rd_data`  out  8  readback byte, first-captured bit in bit 7.
- `rd_valid`  out  1  one-cycle pulse, no backpressure.
- `busy`  out  1  high from the cycle after `start` until the cycle after DONE.
- `done`  out  1  one-cycle pulse at end of pass.
- `prog_clk`  out  1  configuration shift clock.
- `prog_en`  out  1  configuration enable.
- `prog_in`  out  1  serial configuration data.
- `prog_out`  in  1  serial data from the chain tail.

## Operation
- All outputs are registered. Reset value of every output is 0.
- IDLE: `start` → LOAD. `prog_en` rises the next cycle. Bit counter cleared.
- LOAD: `cfg_ready`=1. On handshake, latch the byte into the shift register, reset the in-byte index to 0, and go to SETUP.
  - `prog_clk` is held 0 and `prog_en` held 1 for any stall length.
- SETUP: `prog_clk`=0 and `prog_in`=shreg[7] for `CLK_DIV` cycles. On the last SETUP cycle, sample `prog_out` into the readback shift register (MSB-first). Then go to HIGH.
- HIGH: `prog_clk`=1 for `CLK_DIV` cycles. `prog_in` is held stable. On exit, increment the bit counter and shift shreg left. Next state:
  - bit counter == `CHAIN_LEN` → DONE;
  - else 8 bits of the current byte used → LOAD;
  - else → SETUP.
- Readback: pulse `rd_valid` on every 8th captured bit. After the final bit, if a partial byte remains, emit it left-aligned with zero-filled LSBs.
- DONE: one cycle. `prog_en`=0, `prog_clk`=0, `done`=1, `cfg_ready`=0. Then → IDLE.
- Unused low bits of the last byte when `CHAIN_LEN % 8 != 0` are discarded; no extra `prog_clk` pulses.
- `start` while busy is ignored. `cfg_valid` outside LOAD is ignored; the byte is not consumed.
- `rst` mid-pass: all outputs drop immediately and the FSM returns to IDLE. The fabric keeps a partial configuration; the host restarts the pass.

## Timing
- `start` sampled at cycle 0 → `prog_en`=1 and `cfg_ready`=1 at cycle 1.
- Handshake at cycle t → `prog_in` valid at t+1. First `prog_clk` rise at t+1+`CLK_DIV`.
- Bit period is exactly 2·`CLK_DIV` cycles when data is not stalled.
- Setup time of `prog_in` to the rising `prog_clk` is `CLK_DIV` cycles. Hold time to the next change is `CLK_DIV` cycles.
- Exactly `CHAIN_LEN` rising edges of `prog_clk` per pass.
- `rd_valid` is asserted the cycle after the 8th sample of each byte.
- `done` is asserted in the cycle after the last HIGH phase. `prog_en` falls in that same cycle.

## Structure
- Package `fabric_prog_pkg` holds:
  - the state enum (IDLE, LOAD, SETUP, HIGH, DONE);
  - the byte-width constant;
  - `$clog2`-based counter width helpers.
- One sub-module, `prog_phase_timer`: a `CLK_DIV` down-counter with a `phase_last` strobe. The rest is a single FSM module.

## Test plan
- Reset: assert `rst` asynchronously mid-cycle → all outputs 0 immediately; `cfg_ready`=0 while `rst` is held.
- `CHAIN_LEN`=16, `CLK_DIV`=1, bytes 0xA5, 0x3C → `prog_in` at the 16 rising edges is 1010_0101_0011_1100; exactly 16 pulses; `done` pulses once; `prog_en` low afterward.
- Loopback chain model of 16 flops preloaded 0xBEEF, then program 0x1234 → `rd_data` 0xBE then 0xEF; model ends holding 0x1234.
- `CHAIN_LEN`=12, bytes 0xFF, 0xF0 → 12 pulses, all `prog_in`=1; second readback byte is low nibble 0 (zero-padded).
- Stall `cfg_valid` low 20 cycles between bytes → `prog_clk` stays 0, `prog_en` stays 1, pulse count unchanged. `start` pulsed while busy → no effect.
- `CLK_DIV`=3 → `prog_clk` high and low phases each exactly 3 cycles; `rst` after the 5th edge → immediate idle outputs; a new pass completes normally.
